// File: rtl/if_id_skid_buffer_pkg.sv
// ---------------------------------------------------------------------------
// if_id_skid_buffer_pkg
//   Shared definitions for the IF->ID pipeline register: occupancy/state
//   encodings and the default instruction/address widths and NOP pattern
//   also used by the fetch and decode units.
// ---------------------------------------------------------------------------
package if_id_skid_buffer_pkg;

  localparam int DEF_INSTR_W = 16;
  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_CNT_W   = 8;

  localparam logic [15:0] DEF_NOP_INSTR = 16'h0000;

  // State encoding equals the number of held entries, so it doubles as the
  // occupancy output.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

endpackage

// File: rtl/if_id_skid_buffer_pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_skid_reg
//   Two-entry valid/ready pipeline register. The head register drives the
//   output payload; the skid register catches the one extra entry accepted
//   in the cycle the consumer stalls.
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both high. in_ready depends only on state, reset and hold (never on
//   in_valid or out_ready). While out_valid is high and the entry is not
//   taken, out_data does not change.
//
// Ports
//   i_clock, i_reset      clock, synchronous active-high reset
//   i_clear               drop all entries (head reloaded with EMPTY_VAL)
//   i_hold                freeze: no enqueue, no dequeue
//   i_in_valid/o_in_ready/i_in_data    upstream handshake + payload
//   o_out_valid/i_out_ready/o_out_data downstream handshake + payload
//   o_state               FSM state (== occupancy)
//   o_in_fire             upstream transfer this cycle
// ---------------------------------------------------------------------------
module pipe_skid_reg
  import if_id_skid_buffer_pkg::*;
#(
  parameter int           W         = 32,
  parameter logic [W-1:0] EMPTY_VAL = '0
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_clear,
  input  logic         i_hold,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [W-1:0] i_in_data,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [W-1:0] o_out_data,
  output logic [1:0]   o_state,
  output logic         o_in_fire
);

  logic [1:0]   r_state;
  logic [W-1:0] r_head;
  logic [W-1:0] r_skid;
  logic         w_in_fire;
  logic         w_out_fire;

  assign o_in_ready  = ~i_reset & ~i_hold & (r_state != ST_TWO);
  assign o_out_valid = (r_state != ST_EMPTY);
  assign w_in_fire   = i_in_valid & o_in_ready;
  // hold blocks dequeue even when the consumer is ready.
  assign w_out_fire  = o_out_valid & i_out_ready & ~i_hold;

  assign o_out_data = r_head;
  assign o_state    = r_state;
  assign o_in_fire  = w_in_fire;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_EMPTY;
      r_head  <= EMPTY_VAL;
      r_skid  <= EMPTY_VAL;
    end else if (i_clear) begin
      r_state <= ST_EMPTY;
      r_head  <= EMPTY_VAL;
    end else begin
      // With hold high both fire signals are 0, so every branch below
      // leaves state and data untouched.
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            r_state <= ST_ONE;
            r_head  <= i_in_data;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            r_head <= i_in_data;
          end else if (w_in_fire) begin
            r_state <= ST_TWO;
            r_skid  <= i_in_data;
          end else if (w_out_fire) begin
            r_state <= ST_EMPTY;
            r_head  <= EMPTY_VAL;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only a dequeue can happen.
          if (w_out_fire) begin
            r_state <= ST_ONE;
            r_head  <= r_skid;
          end
        end
        default: begin
          r_state <= ST_EMPTY;
          r_head  <= EMPTY_VAL;
        end
      endcase
    end
  end

endmodule

// File: rtl/if_id_skid_buffer.sv
// ---------------------------------------------------------------------------
// if_id_skid_buffer
//   IF->ID pipeline register with a 2-entry skid buffer so a decode stall
//   never drops a fetched instruction. Adds hazard hold, synchronous
//   flush-to-NOP and a saturating count of discarded entries.
//
// Ports
//   clock, reset                      clock, synchronous active-high reset
//   in_valid/in_ready                 fetch handshake
//   instruction_in, instr_addr_in     fetched instruction and its address
//   hold                              hazard freeze
//   flush                             discard all entries (and any in_fire)
//   out_valid/out_ready               decode handshake
//   instruction_out, instr_addr_out   head entry, NOP/0 when empty
//   occupancy                         entries held (0..2)
//   flush_count                       entries discarded by flush, saturating
// ---------------------------------------------------------------------------
module if_id_skid_buffer
  import if_id_skid_buffer_pkg::*;
#(
  parameter int                 INSTR_W   = DEF_INSTR_W,
  parameter int                 ADDR_W    = DEF_ADDR_W,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(DEF_NOP_INSTR),
  parameter int                 CNT_W     = DEF_CNT_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instruction_in,
  input  logic [ADDR_W-1:0]  instr_addr_in,
  input  logic               hold,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] instruction_out,
  output logic [ADDR_W-1:0]  instr_addr_out,
  output logic [1:0]         occupancy,
  output logic [CNT_W-1:0]   flush_count
);

  localparam int W = INSTR_W + ADDR_W;
  // Payload shown to decode whenever the stage is empty.
  localparam logic [W-1:0] EMPTY_PAYLOAD = {NOP_INSTR, {ADDR_W{1'b0}}};
  localparam logic [CNT_W+1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

  logic [W-1:0]     w_out_data;
  logic [1:0]       w_state;
  logic             w_in_fire;
  logic [CNT_W+1:0] w_flush_sum;
  logic [CNT_W-1:0] r_flush_count;

  pipe_skid_reg #(
    .W         (W),
    .EMPTY_VAL (EMPTY_PAYLOAD)
  ) u_skid (
    .i_clock     (clock),
    .i_reset     (reset),
    .i_clear     (flush),
    .i_hold      (hold),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_data   ({instruction_in, instr_addr_in}),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (w_out_data),
    .o_state     (w_state),
    .o_in_fire   (w_in_fire)
  );

  assign instruction_out = w_out_data[W-1:ADDR_W];
  assign instr_addr_out  = w_out_data[ADDR_W-1:0];
  assign occupancy       = w_state;
  assign flush_count     = r_flush_count;

  // Two guard bits hold count + 2 + 1 without wrapping before the clamp.
  assign w_flush_sum = {2'b00, r_flush_count}
                     + {{CNT_W{1'b0}}, w_state}
                     + {{(CNT_W+1){1'b0}}, w_in_fire};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_flush_count <= '0;
    end else if (flush) begin
      if (w_flush_sum > CNT_MAX) begin
        r_flush_count <= {CNT_W{1'b1}};
      end else begin
        r_flush_count <= w_flush_sum[CNT_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_if_id_skid_buffer.sv
module tb_if_id_skid_buffer;

  localparam logic [15:0] NOP = 16'h0000;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  // main DUT (CNT_W = 8)
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] instruction_in = '0;
  logic [15:0] instr_addr_in = '0;
  logic        hold = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] instruction_out;
  logic [15:0] instr_addr_out;
  logic [1:0]  occupancy;
  logic [7:0]  flush_count;

  // second DUT (CNT_W = 2) for saturation
  logic        s_reset = 1'b1;
  logic        s_in_valid = 1'b0;
  logic        s_in_ready;
  logic [15:0] s_instruction_in = '0;
  logic [15:0] s_instr_addr_in = '0;
  logic        s_hold = 1'b0;
  logic        s_flush = 1'b0;
  logic        s_out_valid;
  logic        s_out_ready = 1'b0;
  logic [15:0] s_instruction_out;
  logic [15:0] s_instr_addr_out;
  logic [1:0]  s_occupancy;
  logic [1:0]  s_flush_count;

  int total = 0;
  int bad = 0;

  // scoreboard model of the main DUT
  logic [31:0] exp_q[$];
  int          m_cnt = 0;

  if_id_skid_buffer dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instruction_in(instruction_in), .instr_addr_in(instr_addr_in),
    .hold(hold), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .instruction_out(instruction_out), .instr_addr_out(instr_addr_out),
    .occupancy(occupancy), .flush_count(flush_count)
  );

  if_id_skid_buffer #(.CNT_W(2)) dut2 (
    .clock(clock), .reset(s_reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .instruction_in(s_instruction_in), .instr_addr_in(s_instr_addr_in),
    .hold(s_hold), .flush(s_flush), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .instruction_out(s_instruction_out), .instr_addr_out(s_instr_addr_out),
    .occupancy(s_occupancy), .flush_count(s_flush_count)
  );

  // Model update on every active edge: push on in_fire, pop on out_fire.
  always @(posedge clock) begin
    int  sz;
    int  sum;
    bit  m_ready;
    bit  m_in_fire;
    bit  m_out_fire;
    sz         = exp_q.size();
    m_ready    = !reset && !hold && (sz != 2);
    m_in_fire  = in_valid && m_ready;
    m_out_fire = (sz != 0) && out_ready && !hold;
    if (reset) begin
      exp_q.delete();
      m_cnt = 0;
    end else if (flush) begin
      sum = m_cnt + sz + (m_in_fire ? 1 : 0);
      m_cnt = (sum > 255) ? 255 : sum;
      exp_q.delete();
    end else begin
      if (m_out_fire) void'(exp_q.pop_front());
      if (m_in_fire) exp_q.push_back({instruction_in, instr_addr_in});
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    @(negedge clock);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0h exp=0", out_valid); end
    total++; if (instruction_out !== NOP) begin bad++; $display("FAIL rst_instr got=%0h exp=%0h", instruction_out, NOP); end
    total++; if (instr_addr_out !== 16'h0000) begin bad++; $display("FAIL rst_addr got=%0h exp=0", instr_addr_out); end
    total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL rst_occ got=%0d exp=0", occupancy); end
    total++; if (flush_count !== 8'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", flush_count); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%0h exp=0", in_ready); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_push;
    in_valid = 1'b1; instruction_in = 16'h1234; instr_addr_in = 16'h0010; out_ready = 1'b1;
    @(negedge clock);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL push_in_ready got=%0h exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    @(negedge clock);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL push_valid got=%0h exp=1", out_valid); end
    total++; if (instruction_out !== 16'h1234) begin bad++; $display("FAIL push_instr got=%0h exp=1234", instruction_out); end
    total++; if (instr_addr_out !== 16'h0010) begin bad++; $display("FAIL push_addr got=%0h exp=0010", instr_addr_out); end
    total++; if (occupancy !== 2'd1) begin bad++; $display("FAIL push_occ got=%0d exp=1", occupancy); end
    tick();
    @(negedge clock);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_valid got=%0h exp=0", out_valid); end
    total++; if (instruction_out !== NOP) begin bad++; $display("FAIL drain_instr got=%0h exp=%0h", instruction_out, NOP); end
    total++; if (instr_addr_out !== 16'h0000) begin bad++; $display("FAIL drain_addr got=%0h exp=0", instr_addr_out); end
    total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL drain_occ got=%0d exp=0", occupancy); end
    tick();
  endtask

  task automatic test_stall_stream;
    int idx = 0;
    int delivered = 0;
    bit exp_ready;
    bit accepted;
    for (int cyc = 0; cyc < 40 && delivered < 8; cyc++) begin
      in_valid       = (idx < 8);
      instruction_in = 16'hA000 + 16'(idx);
      instr_addr_in  = 16'h0100 + 16'(idx * 2);
      out_ready      = (cyc >= 4);
      @(negedge clock);
      exp_ready = (exp_q.size() != 2);
      total++; if (in_ready !== exp_ready) begin bad++; $display("FAIL stream_in_ready cyc=%0d got=%0h exp=%0h", cyc, in_ready, exp_ready); end
      if (cyc == 2 || cyc == 3) begin
        total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL stream_full_occ cyc=%0d got=%0d exp=2", cyc, occupancy); end
        total++; if (instruction_out !== 16'hA000) begin bad++; $display("FAIL stream_head cyc=%0d got=%0h exp=a000", cyc, instruction_out); end
      end
      if (exp_q.size() != 0 && out_ready) begin
        total++;
        if ({instruction_out, instr_addr_out} !== {16'hA000 + 16'(delivered), 16'h0100 + 16'(delivered * 2)}) begin
          bad++;
          $display("FAIL stream_order n=%0d got=%0h@%0h exp=%0h@%0h", delivered, instruction_out, instr_addr_out,
                   16'hA000 + 16'(delivered), 16'h0100 + 16'(delivered * 2));
        end
        delivered++;
      end
      accepted = in_valid && exp_ready;
      tick();
      if (accepted) idx++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    total++; if (delivered != 8) begin bad++; $display("FAIL stream_count got=%0d exp=8", delivered); end
    @(negedge clock);
    total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL stream_empty_occ got=%0d exp=0", occupancy); end
    tick();
  endtask

  task automatic test_flush_full;
    out_ready = 1'b0;
    in_valid = 1'b1; instruction_in = 16'hB001; instr_addr_in = 16'h0300;
    tick();
    instruction_in = 16'hB002; instr_addr_in = 16'h0302;
    tick();
    flush = 1'b1; instruction_in = 16'hB003; instr_addr_in = 16'h0304;
    @(negedge clock);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%0h exp=0", in_ready); end
    total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL flush_pre_occ got=%0d exp=2", occupancy); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clock);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0h exp=0", out_valid); end
    total++; if (instruction_out !== NOP) begin bad++; $display("FAIL flush_instr got=%0h exp=%0h", instruction_out, NOP); end
    total++; if (instr_addr_out !== 16'h0000) begin bad++; $display("FAIL flush_addr got=%0h exp=0", instr_addr_out); end
    total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL flush_occ got=%0d exp=0", occupancy); end
    total++; if (flush_count !== 8'd2) begin bad++; $display("FAIL flush_cnt got=%0d exp=2", flush_count); end
    tick();
  endtask

  task automatic test_hold;
    out_ready = 1'b0;
    in_valid = 1'b1; instruction_in = 16'h5555; instr_addr_in = 16'h0200;
    tick();
    hold = 1'b1; out_ready = 1'b1; instruction_in = 16'h6666; instr_addr_in = 16'h0202;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL hold_in_ready c=%0d got=%0h exp=0", c, in_ready); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL hold_valid c=%0d got=%0h exp=1", c, out_valid); end
      total++; if ({instruction_out, instr_addr_out} !== 32'h5555_0200) begin bad++; $display("FAIL hold_payload c=%0d got=%0h@%0h exp=5555@0200", c, instruction_out, instr_addr_out); end
      total++; if (occupancy !== 2'd1) begin bad++; $display("FAIL hold_occ c=%0d got=%0d exp=1", c, occupancy); end
      tick();
    end
    hold = 1'b0; in_valid = 1'b0;
    @(negedge clock);
    total++; if (instruction_out !== 16'h5555) begin bad++; $display("FAIL release_instr got=%0h exp=5555", instruction_out); end
    tick();
    out_ready = 1'b0;
    @(negedge clock);
    total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL release_occ got=%0d exp=0", occupancy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL release_valid got=%0h exp=0", out_valid); end
    tick();
  endtask

  task automatic test_saturate;
    int exp_c;
    s_reset = 1'b1;
    tick();
    s_reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      s_in_valid = 1'b1; s_instruction_in = 16'hC000 + 16'(k); s_instr_addr_in = 16'(k * 2);
      tick();
      s_in_valid = 1'b0; s_flush = 1'b1;
      @(negedge clock);
      total++; if (s_occupancy !== 2'd1) begin bad++; $display("FAIL sat_occ k=%0d got=%0d exp=1", k, s_occupancy); end
      tick();
      s_flush = 1'b0;
      exp_c = (k > 3) ? 3 : k;
      @(negedge clock);
      total++; if (s_flush_count !== 2'(exp_c)) begin bad++; $display("FAIL sat_cnt k=%0d got=%0d exp=%0d", k, s_flush_count, exp_c); end
    end
    tick();
    s_in_valid = 1'b1; s_out_ready = 1'b0;
    tick();
    tick();
    s_in_valid = 1'b0;
    @(negedge clock);
    total++; if (s_occupancy !== 2'd2) begin bad++; $display("FAIL rst2_pre_occ got=%0d exp=2", s_occupancy); end
    s_reset = 1'b1;
    tick();
    @(negedge clock);
    total++; if (s_out_valid !== 1'b0) begin bad++; $display("FAIL rst2_valid got=%0h exp=0", s_out_valid); end
    total++; if ({s_instruction_out, s_instr_addr_out} !== 32'h0) begin bad++; $display("FAIL rst2_payload got=%0h@%0h exp=0@0", s_instruction_out, s_instr_addr_out); end
    total++; if (s_occupancy !== 2'd0) begin bad++; $display("FAIL rst2_occ got=%0d exp=0", s_occupancy); end
    total++; if (s_flush_count !== 2'd0) begin bad++; $display("FAIL rst2_cnt got=%0d exp=0", s_flush_count); end
    total++; if (s_in_ready !== 1'b0) begin bad++; $display("FAIL rst2_in_ready got=%0h exp=0", s_in_ready); end
    s_reset = 1'b0;
    tick();
  endtask

  task automatic test_random;
    logic [31:0] exp_head;
    bit          exp_ready;
    int          sz;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      reset          = ($urandom_range(0, 999) == 0);
      in_valid       = ($urandom_range(0, 9) < 7);
      instruction_in = 16'($urandom_range(0, 65535));
      instr_addr_in  = 16'($urandom_range(0, 65535));
      out_ready      = ($urandom_range(0, 9) < 6);
      hold           = ($urandom_range(0, 9) == 0);
      flush          = ($urandom_range(0, 29) == 0);
      @(negedge clock);
      sz        = exp_q.size();
      exp_head  = (sz != 0) ? exp_q[0] : {NOP, 16'h0000};
      exp_ready = !reset && !hold && (sz != 2);
      total++; if (occupancy !== 2'(sz)) begin bad++; $display("FAIL rnd_occ cyc=%0d got=%0d exp=%0d", cyc, occupancy, sz); end
      total++; if (out_valid !== (sz != 0)) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%0h exp=%0h", cyc, out_valid, sz != 0); end
      total++; if ({instruction_out, instr_addr_out} !== exp_head) begin bad++; $display("FAIL rnd_payload cyc=%0d got=%0h%0h exp=%0h", cyc, instruction_out, instr_addr_out, exp_head); end
      total++; if (in_ready !== exp_ready) begin bad++; $display("FAIL rnd_in_ready cyc=%0d got=%0h exp=%0h", cyc, in_ready, exp_ready); end
      total++; if (flush_count !== 8'(m_cnt)) begin bad++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", cyc, flush_count, m_cnt); end
      tick();
    end
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; hold = 1'b0; flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_stall_stream();
    test_flush_full();
    test_hold();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
